dep_type_rule_loader: RTL and testbench



---
 rtl/dep_cfg_pkg.sv | 87 ++++++++
 rtl/dep_rule_rec_unpack.sv | 40 ++++
 rtl/dep_type_rule_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dep_type_rule_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dep_cfg_pkg.sv
// -----------------------------------------------------------------------------
// dep_cfg_pkg
// Shared definitions for the deparser type-rule loader:
//   - rule-table geometry macros (defaults provided when not set externally)
//   - config header opcodes and bit positions
//   - rule_rec_t, the packed rule record (LSB-first: valid, typeData, typeMask,
//     typeOffset, keyOffset, keyReplaceOffset, headShift, metaShift)
//   - REC_W / NWORDS and FSM state encoding
// Optional feature macro used by the loader: DEP_RULE_SHADOW_EN.
// -----------------------------------------------------------------------------
`ifndef RULE_NUM
`define RULE_NUM 8
`endif
`ifndef TYPE_NUM
`define TYPE_NUM 2
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 16
`endif
`ifndef TYPE_OFFSET_WIDTH
`define TYPE_OFFSET_WIDTH 8
`endif
`ifndef KEY_FILED_NUM
`define KEY_FILED_NUM 4
`endif
`ifndef KEY_OFFSET_WIDTH
`define KEY_OFFSET_WIDTH 6
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 8
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 8
`endif

package dep_cfg_pkg;

  // Header layout is fixed for 32-bit config words.
  localparam int CFG_W = 32;

  localparam int RULE_NUM = `RULE_NUM;
  localparam int IDX_W    = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;

  localparam logic [7:0] OP_WRITE      = 8'h01;
  localparam logic [7:0] OP_INVALIDATE = 8'h02;
  localparam logic [7:0] OP_READ       = 8'h03;

  localparam int HDR_OP_MSB  = 31;
  localparam int HDR_OP_LSB  = 24;
  localparam int HDR_IDX_MSB = 7;
  localparam int HDR_IDX_LSB = 0;

  localparam int TD_W = `TYPE_NUM * `TYPE_WIDTH;
  localparam int TO_W = `TYPE_NUM * `TYPE_OFFSET_WIDTH;
  localparam int KO_W = `KEY_FILED_NUM * (`KEY_OFFSET_WIDTH + 1);
  localparam int KR_W = `KEY_FILED_NUM * `KEY_OFFSET_WIDTH;
  localparam int HS_W = `HEAD_SHIFT_WIDTH;
  localparam int MS_W = `META_SHIFT_WIDTH;

  // First member is the MSB, so valid ends up at bit 0.
  typedef struct packed {
    logic [MS_W-1:0] meta_shift;
    logic [HS_W-1:0] head_shift;
    logic [KR_W-1:0] key_replace_offset;
    logic [KO_W-1:0] key_offset;
    logic [TO_W-1:0] type_offset;
    logic [TD_W-1:0] type_mask;
    logic [TD_W-1:0] type_data;
    logic            valid;
  } rule_rec_t;

  localparam int REC_W  = 1 + 2 * TD_W + TO_W
                        + `KEY_FILED_NUM * (2 * `KEY_OFFSET_WIDTH + 1)
                        + HS_W + MS_W;
  localparam int NWORDS = (REC_W + CFG_W - 1) / CFG_W;
  localparam int BUF_W  = NWORDS * CFG_W;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RDOUT  = 3'd4
  } state_t;

endpackage

// File: rtl/dep_rule_rec_unpack.sv
// -----------------------------------------------------------------------------
// dep_rule_rec_unpack
// Combinational split of a packed rule record onto the typeRule_* fields.
// Ports:
//   rec_bits            in   REC_W packed record (rule_rec_t layout)
//   valid               out  rule valid bit
//   type_data/type_mask out  match data / mask
//   type_offset         out  type offsets
//   key_offset          out  key offsets (top bit of each field = valid)
//   key_replace_offset  out  replace slot per key
//   head_shift          out  header shift
//   meta_shift          out  meta shift
// -----------------------------------------------------------------------------
module dep_rule_rec_unpack
  import dep_cfg_pkg::*;
(
  input  logic [REC_W-1:0] rec_bits,
  output logic             valid,
  output logic [TD_W-1:0]  type_data,
  output logic [TD_W-1:0]  type_mask,
  output logic [TO_W-1:0]  type_offset,
  output logic [KO_W-1:0]  key_offset,
  output logic [KR_W-1:0]  key_replace_offset,
  output logic [HS_W-1:0]  head_shift,
  output logic [MS_W-1:0]  meta_shift
);

  rule_rec_t rec_s;

  assign rec_s              = rule_rec_t'(rec_bits);
  assign valid              = rec_s.valid;
  assign type_data          = rec_s.type_data;
  assign type_mask          = rec_s.type_mask;
  assign type_offset        = rec_s.type_offset;
  assign key_offset         = rec_s.key_offset;
  assign key_replace_offset = rec_s.key_replace_offset;
  assign head_shift         = rec_s.head_shift;
  assign meta_shift         = rec_s.meta_shift;

endmodule

// File: rtl/dep_type_rule_loader.sv
// -----------------------------------------------------------------------------
// dep_type_rule_loader
// Control-plane writer for the deparser type-lookup rule table. Decodes a
// 32-bit config word stream (header + payload words), assembles one rule
// record and commits it as a single-cycle one-hot write strobe with the
// registered typeRule_* fields. Erroneous commands are counted and drained.
// Optional macro DEP_RULE_SHADOW_EN: shadow copy of all rules plus a READ
// command that streams a stored record out on the o_rd_* port.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_cfg_valid/data/last     config word stream; o_cfg_ready accepts
//   o_rule_wren               one-hot rule write strobe (one cycle)
//   o_typeRule_*              committed rule fields (held between commits)
//   o_cmd_cnt / o_err_cnt     committed / rejected commands, saturating
//   o_rd_valid/data/last,
//   i_rd_ready                readback stream (DEP_RULE_SHADOW_EN only)
// -----------------------------------------------------------------------------
module dep_type_rule_loader
  import dep_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cfg_valid,
  input  logic [CFG_WIDTH-1:0] i_cfg_data,
  input  logic                 i_cfg_last,
  output logic                 o_cfg_ready,
  output logic [`RULE_NUM-1:0] o_rule_wren,
  output logic                 o_typeRule_valid,
  output logic [TD_W-1:0]      o_typeRule_typeData,
  output logic [TD_W-1:0]      o_typeRule_typeMask,
  output logic [TO_W-1:0]      o_typeRule_typeOffset,
  output logic [KO_W-1:0]      o_typeRule_keyOffset,
  output logic [KR_W-1:0]      o_typeRule_keyReplaceOffset,
  output logic [HS_W-1:0]      o_typeRule_headShift,
  output logic [MS_W-1:0]      o_typeRule_metaShift,
  output logic [CNT_WIDTH-1:0] o_cmd_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt
`ifdef DEP_RULE_SHADOW_EN
  ,
  output logic                 o_rd_valid,
  output logic [CFG_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_last,
  input  logic                 i_rd_ready
`endif
);

  localparam logic [WCNT_W-1:0]    LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [WCNT_W-1:0]    WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [`RULE_NUM-1:0] WREN_ONE  = {{(`RULE_NUM-1){1'b0}}, 1'b1};
  localparam logic [BUF_W-1:0]     WORD_MASK = BUF_W'({CFG_WIDTH{1'b1}});

  state_t                state_r, state_next;
  logic [REC_W-1:0]      rec_r, rec_next, out_rec_r;
  logic [WCNT_W-1:0]     wcnt_r, wcnt_next;
  logic [IDX_W-1:0]      idx_r, idx_next;
  logic [`RULE_NUM-1:0]  wren_r;
  logic                  ready_r;
  logic [CNT_WIDTH-1:0]  cmd_cnt_r, err_cnt_r;
  logic                  xfer_s, commit_s, err_s, idx_ok_s;
  logic [7:0]            hdr_op_s, hdr_idx_s;
  int                    word_sh_s;

`ifdef DEP_RULE_SHADOW_EN
  logic [REC_W-1:0]      shadow_r [RULE_NUM];
  logic [WCNT_W-1:0]     rcnt_r, rcnt_next;
  logic                  rd_fire_s;
  int                    rd_sh_s;

  assign o_rd_valid = (state_r == ST_RDOUT);
  assign o_rd_last  = o_rd_valid & (rcnt_r == LAST_WORD);
  assign rd_fire_s  = o_rd_valid & i_rd_ready;
  assign rd_sh_s    = int'(rcnt_r) * CFG_WIDTH;
  // Pad bits above REC_W read back as zero because the shadow holds only REC_W.
  assign o_rd_data  = CFG_WIDTH'(BUF_W'(shadow_r[idx_r]) >> rd_sh_s);
`endif

  assign xfer_s      = i_cfg_valid & ready_r;
  assign hdr_op_s    = i_cfg_data[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_idx_s   = i_cfg_data[HDR_IDX_MSB:HDR_IDX_LSB];
  assign idx_ok_s    = (hdr_idx_s < 8'(RULE_NUM));
  assign word_sh_s   = int'(wcnt_r) * CFG_WIDTH;
  assign o_cfg_ready = ready_r;
  assign o_rule_wren = wren_r;
  assign o_cmd_cnt   = cmd_cnt_r;
  assign o_err_cnt   = err_cnt_r;

  // Next-state, record assembly and commit/error decode.
  always_comb begin
    state_next = state_r;
    rec_next   = rec_r;
    wcnt_next  = wcnt_r;
    idx_next   = idx_r;
    commit_s   = 1'b0;
    err_s      = 1'b0;
`ifdef DEP_RULE_SHADOW_EN
    rcnt_next  = rcnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          idx_next = hdr_idx_s[IDX_W-1:0];
          if (!idx_ok_s) begin
            err_s      = 1'b1;
            state_next = i_cfg_last ? ST_IDLE : ST_DRAIN;
          end else begin
            case (hdr_op_s)
              OP_WRITE: begin
                // A WRITE must be followed by payload words.
                if (i_cfg_last) begin
                  err_s      = 1'b1;
                  state_next = ST_IDLE;
                end else begin
                  wcnt_next  = '0;
                  state_next = ST_LOAD;
                end
              end
              OP_INVALIDATE: begin
                if (i_cfg_last) begin
                  rec_next   = '0;
                  commit_s   = 1'b1;
                  state_next = ST_COMMIT;
                end else begin
                  err_s      = 1'b1;
                  state_next = ST_DRAIN;
                end
              end
`ifdef DEP_RULE_SHADOW_EN
              OP_READ: begin
                if (i_cfg_last) begin
                  rcnt_next  = '0;
                  state_next = ST_RDOUT;
                end else begin
                  err_s      = 1'b1;
                  state_next = ST_DRAIN;
                end
              end
`endif
              default: begin
                err_s      = 1'b1;
                state_next = i_cfg_last ? ST_IDLE : ST_DRAIN;
              end
            endcase
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          // Drop the word into its 32-bit slot; pad bits past REC_W fall off.
          rec_next  = REC_W'((BUF_W'(rec_r) & ~(WORD_MASK << word_sh_s))
                             | (BUF_W'(i_cfg_data) << word_sh_s));
          wcnt_next = wcnt_r + WCNT_ONE;
          if (wcnt_r == LAST_WORD) begin
            if (i_cfg_last) begin
              commit_s   = 1'b1;
              state_next = ST_COMMIT;
            end else begin
              err_s      = 1'b1;
              state_next = ST_DRAIN;
            end
          end else if (i_cfg_last) begin
            err_s      = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_LOAD;
          end
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (xfer_s && i_cfg_last) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
`ifdef DEP_RULE_SHADOW_EN
      ST_RDOUT: begin
        if (rd_fire_s) begin
          if (rcnt_r == LAST_WORD) begin
            state_next = ST_IDLE;
          end else begin
            rcnt_next  = rcnt_r + WCNT_ONE;
            state_next = ST_RDOUT;
          end
        end else begin
          state_next = ST_RDOUT;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, record, strobe, registered field outputs and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      rec_r     <= '0;
      out_rec_r <= '0;
      wcnt_r    <= '0;
      idx_r     <= '0;
      wren_r    <= '0;
      ready_r   <= 1'b0;
      cmd_cnt_r <= '0;
      err_cnt_r <= '0;
    end else begin
      state_r <= state_next;
      rec_r   <= rec_next;
      wcnt_r  <= wcnt_next;
      idx_r   <= idx_next;
      // Ready is registered from the next state so it is low exactly in COMMIT/RDOUT.
      ready_r <= (state_next != ST_COMMIT) && (state_next != ST_RDOUT);
      if (commit_s) begin
        wren_r    <= WREN_ONE << idx_next;
        out_rec_r <= rec_next;
      end else begin
        wren_r    <= '0;
      end
      if (commit_s && (cmd_cnt_r != '1)) begin
        cmd_cnt_r <= cmd_cnt_r + CNT_ONE;
      end
      if (err_s && (err_cnt_r != '1)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef DEP_RULE_SHADOW_EN
  // Shadow copy of every committed record plus the readback word counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcnt_r <= '0;
      for (int i = 0; i < RULE_NUM; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      rcnt_r <= rcnt_next;
      if (commit_s) begin
        shadow_r[idx_next] <= rec_next;
      end
    end
  end
`endif

  dep_rule_rec_unpack u_unpack (
    .rec_bits           (out_rec_r),
    .valid              (o_typeRule_valid),
    .type_data          (o_typeRule_typeData),
    .type_mask          (o_typeRule_typeMask),
    .type_offset        (o_typeRule_typeOffset),
    .key_offset         (o_typeRule_keyOffset),
    .key_replace_offset (o_typeRule_keyReplaceOffset),
    .head_shift         (o_typeRule_headShift),
    .meta_shift         (o_typeRule_metaShift)
  );

endmodule

// File: tb/tb_dep_type_rule_loader.sv
`timescale 1ns/1ps
module tb_dep_type_rule_loader;

  localparam int TDW  = `TYPE_NUM * `TYPE_WIDTH;
  localparam int TOW  = `TYPE_NUM * `TYPE_OFFSET_WIDTH;
  localparam int KOW  = `KEY_FILED_NUM * (`KEY_OFFSET_WIDTH + 1);
  localparam int KRW  = `KEY_FILED_NUM * `KEY_OFFSET_WIDTH;
  localparam int HSW  = `HEAD_SHIFT_WIDTH;
  localparam int MSW  = `META_SHIFT_WIDTH;
  localparam int RW   = 1 + 2 * TDW + TOW + KOW + KRW + HSW + MSW;
  localparam int NW   = (RW + 31) / 32;
  localparam int B_TD = 1;
  localparam int B_TM = B_TD + TDW;
  localparam int B_TO = B_TM + TDW;
  localparam int B_KO = B_TO + TOW;
  localparam int B_KR = B_KO + KOW;
  localparam int B_HS = B_KR + KRW;
  localparam int B_MS = B_HS + HSW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic [31:0]          cfg_data = 32'h0;
  logic                 cfg_last = 1'b0;
  logic                 cfg_ready;
  logic [`RULE_NUM-1:0] rule_wren;
  logic                 tr_valid;
  logic [TDW-1:0]       tr_tdata, tr_tmask;
  logic [TOW-1:0]       tr_toff;
  logic [KOW-1:0]       tr_koff;
  logic [KRW-1:0]       tr_krep;
  logic [HSW-1:0]       tr_hs;
  logic [MSW-1:0]       tr_ms;
  logic [15:0]          cmd_cnt, err_cnt;
`ifdef DEP_RULE_SHADOW_EN
  logic                 rd_valid, rd_last;
  logic [31:0]          rd_data;
  logic                 rd_ready = 1'b0;
`endif

  dep_type_rule_loader dut (
    .i_clk                       (clk),
    .i_rst_n                     (rst_n),
    .i_cfg_valid                 (cfg_valid),
    .i_cfg_data                  (cfg_data),
    .i_cfg_last                  (cfg_last),
    .o_cfg_ready                 (cfg_ready),
    .o_rule_wren                 (rule_wren),
    .o_typeRule_valid            (tr_valid),
    .o_typeRule_typeData         (tr_tdata),
    .o_typeRule_typeMask         (tr_tmask),
    .o_typeRule_typeOffset       (tr_toff),
    .o_typeRule_keyOffset        (tr_koff),
    .o_typeRule_keyReplaceOffset (tr_krep),
    .o_typeRule_headShift        (tr_hs),
    .o_typeRule_metaShift        (tr_ms),
    .o_cmd_cnt                   (cmd_cnt),
    .o_err_cnt                   (err_cnt)
`ifdef DEP_RULE_SHADOW_EN
    ,
    .o_rd_valid                  (rd_valid),
    .o_rd_data                   (rd_data),
    .o_rd_last                   (rd_last),
    .i_rd_ready                  (rd_ready)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    wren;
    logic [RW-1:0] rec;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] w [NW];
  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  int          e_cmd = 0;
  int          e_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe pops the oldest expected commit.
  always @(negedge clk) begin
    exp_t e;
    if (rule_wren !== 8'h00) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", rule_wren, 8'h00);
      end else begin
        e = sb.pop_front();
        chk("sb_wren", rule_wren, e.wren);
        chk("sb_valid", tr_valid, e.rec[0]);
        chk("sb_typeData", tr_tdata, e.rec[B_TD +: TDW]);
        chk("sb_typeMask", tr_tmask, e.rec[B_TM +: TDW]);
        chk("sb_typeOffset", tr_toff, e.rec[B_TO +: TOW]);
        chk("sb_keyOffset", tr_koff, e.rec[B_KO +: KOW]);
        chk("sb_keyReplace", tr_krep, e.rec[B_KR +: KRW]);
        chk("sb_headShift", tr_hs, e.rec[B_HS +: HSW]);
        chk("sb_metaShift", tr_ms, e.rec[B_MS +: MSW]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("ready_timeout", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // WRITE header + payload; last is raised on word index last_at.
  task automatic send_write(input logic [7:0] idx, input int last_at, input bit ok);
    logic [NW*32-1:0] p;
    logic [7:0]       one;
    logic [7:0]       exp_wren;
    one = 8'h01;
    for (int n = 0; n < NW; n++) w[n] = $urandom;
    w[0][0]    = 1'b1;
    w[0][16:1] = 16'h0800;
    for (int n = 0; n < NW; n++) p[n*32 +: 32] = w[n];
    exp_wren = one << idx[2:0];
    send_word({8'h01, 16'h0000, idx}, 1'b0);
    if (ok) sb.push_back({exp_wren, p[RW-1:0]});
    for (int n = 0; n <= last_at; n++) begin
      send_word((n < NW) ? w[n] : $urandom, (n == last_at));
    end
    if (ok) begin
      e_cmd++;
      chk("commit_latency_wren", rule_wren, exp_wren);
      chk("commit_ready_low", cfg_ready, 1'b0);
    end else begin
      e_err++;
    end
  endtask

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_wren", rule_wren, 8'h00);
    chk("rst_valid", tr_valid, 1'b0);
    chk("rst_typeData", tr_tdata, 32'h0);
    chk("rst_cmd_cnt", cmd_cnt, 16'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);
    rst_n = 1'b1;

    // WRITE idx 3
    send_write(8'd3, NW - 1, 1'b1);
    idle(2);
    chk("w3_cmd_cnt", cmd_cnt, e_cmd);
    chk("w3_err_cnt", err_cnt, e_err);
    chk("w3_wren_pulse_ends", rule_wren, 8'h00);
    chk("w3_hold_typeData0", tr_tdata[15:0], 16'h0800);
    chk("w3_hold_valid", tr_valid, 1'b1);

    // INVALIDATE idx 7
    sb.push_back({8'h80, {RW{1'b0}}});
    send_word({8'h02, 16'h0000, 8'h07}, 1'b1);
    e_cmd++;
    chk("inv7_latency_wren", rule_wren, 8'h80);
    idle(2);
    chk("inv7_cmd_cnt", cmd_cnt, e_cmd);
    chk("inv7_valid", tr_valid, 1'b0);

    // Out-of-range index: drained, then a good command
    s0 = strobes;
    send_write(8'd9, NW - 1, 1'b0);
    idle(2);
    chk("idx9_err_cnt", err_cnt, e_err);
    chk("idx9_no_strobe", strobes, s0);
    send_write(8'd1, NW - 1, 1'b1);
    idle(2);
    chk("after_drain_cmd_cnt", cmd_cnt, e_cmd);

    // Early last on payload word 0
    s0 = strobes;
    send_write(8'd2, 0, 1'b0);
    idle(1);
    chk("early_last_err_cnt", err_cnt, e_err);
    // Missing last on final payload word, 3 extra words
    send_write(8'd4, NW - 1 + 3, 1'b0);
    idle(1);
    chk("missing_last_err_cnt", err_cnt, e_err);
    chk("bad_writes_no_strobe", strobes, s0);
    send_write(8'd6, NW - 1, 1'b1);
    idle(2);
    chk("w6_cmd_cnt", cmd_cnt, e_cmd);

    // Unknown opcode, WRITE without payload, INVALIDATE without last
    send_word({8'h05, 16'h0000, 8'h01}, 1'b1);
    e_err++;
    send_word({8'h01, 16'h0000, 8'h02}, 1'b1);
    e_err++;
    send_word({8'h02, 16'h0000, 8'h03}, 1'b0);
    send_word(32'hdead_beef, 1'b1);
    e_err++;
    idle(1);
    chk("misc_err_cnt", err_cnt, e_err);

`ifdef DEP_RULE_SHADOW_EN
    begin
      logic [NW*32-1:0] p;
      int k;
      send_write(8'd5, NW - 1, 1'b1);
      idle(2);
      for (int n = 0; n < NW; n++) p[n*32 +: 32] = w[n];
      for (int b = RW; b < NW * 32; b++) p[b] = 1'b0;
      send_word({8'h03, 16'h0000, 8'h05}, 1'b1);
      k = 0;
      for (int c = 0; c < 40 && k < NW; c++) begin
        @(negedge clk);
        rd_ready = c[0];
        #1;
        if (rd_valid && rd_ready) begin
          chk("rd_data", rd_data, p[k*32 +: 32]);
          chk("rd_last", rd_last, (k == NW - 1));
          k++;
        end
      end
      rd_ready = 1'b0;
      chk("rd_word_count", k, NW);
    end
`else
    send_word({8'h03, 16'h0000, 8'h05}, 1'b1);
    e_err++;
    idle(1);
    chk("read_disabled_err_cnt", err_cnt, e_err);
`endif
    idle(1);
    chk("cmd_cnt_before_reset", cmd_cnt, e_cmd);

    // Reset in the middle of LOAD
    send_word({8'h01, 16'h0000, 8'h05}, 1'b0);
    send_word(32'h1234_5679, 1'b0);
    send_word(32'h0bad_cafe, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", rule_wren, 8'h00);
    chk("midrst_ready", cfg_ready, 1'b0);
    chk("midrst_cmd_cnt", cmd_cnt, 16'h0);
    chk("midrst_err_cnt", err_cnt, 16'h0);
    chk("midrst_valid", tr_valid, 1'b0);
    chk("midrst_typeData", tr_tdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e_cmd = 0;
    e_err = 0;
    send_write(8'd0, NW - 1, 1'b1);
    idle(2);
    chk("post_rst_cmd_cnt", cmd_cnt, e_cmd);
    chk("post_rst_err_cnt", err_cnt, e_err);

    idle(2);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
